// File: rtl/vs_vec_core.sv
// vs_vec_core: N-lane, 3-stage pipelined vector ALU for the vertex shader.
// Element-wise ADD/MUL/MAX plus a lane-masked dot product (DP) reduced into
// lane 0. Valid/ready back-pressure on both sides; a stall freezes every stage.
// Optional build macro VS_VEC_SATURATE_EN: clamp overflowing ADD/MUL/DP
// results to the signed range instead of wrapping.
module vs_vec_core #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        iValid,
  output logic                        oReady,
  input  logic [LANES*DATA_WIDTH-1:0] iA,
  input  logic [LANES*DATA_WIDTH-1:0] iB,
  input  logic [OP_WIDTH-1:0]         iALU_Op,
  input  logic [LANES-1:0]            iLaneMask,
  output logic                        oValid,
  input  logic                        iReady,
  output logic [LANES*DATA_WIDTH-1:0] oResult,
  output logic                        oZero,
  output logic                        oOverflow
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DW;
  localparam int SW = PW + $clog2(LANES);

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_DP  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_MAX = OP_WIDTH'(3);

`ifdef VS_VEC_SATURATE_EN
  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};
`endif

  // Pipeline control: the whole pipe freezes while a result waits downstream
  logic stall;

  // Stage 1: registered operands
  logic                  s1_valid_q;
  logic [LANES*DW-1:0]   s1_a_q;
  logic [LANES*DW-1:0]   s1_b_q;
  logic [OP_WIDTH-1:0]   s1_op_q;
  logic [LANES-1:0]      s1_mask_q;

  // Stage 2: per-lane results, overflow flags and masked DP products
  logic [LANES-1:0][DW-1:0] lane_res_d;
  logic [LANES-1:0]         lane_ovf_d;
  logic [LANES-1:0][PW-1:0] lane_prod_d;

  logic                     s2_valid_q;
  logic [OP_WIDTH-1:0]      s2_op_q;
  logic [LANES-1:0][DW-1:0] s2_res_q;
  logic [LANES-1:0]         s2_ovf_q;
  logic [LANES-1:0][PW-1:0] s2_prod_q;

  // Stage 3: reduction and output registers
  logic [SW-1:0]         dp_sum;
  logic                  dp_ovf;
  logic [DW-1:0]         dp_lane0;
  logic [LANES*DW-1:0]   s3_res_d;
  logic                  s3_ovf_d;
  logic                  s3_zero_d;

  logic                  out_valid_q;
  logic [LANES*DW-1:0]   out_res_q;
  logic                  out_zero_q;
  logic                  out_ovf_q;

  assign stall  = out_valid_q & ~iReady;
  assign oReady = ~stall;

  // Capture the incoming operands whenever the pipe is free to advance
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_mask_q  <= '0;
    end else if (!stall) begin
      s1_valid_q <= iValid;
      if (iValid) begin
        s1_a_q    <= iA;
        s1_b_q    <= iB;
        s1_op_q   <= iALU_Op;
        s1_mask_q <= iLaneMask;
      end
    end
  end

  // Per-lane arithmetic on the stage-1 operands
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [DW-1:0] a_l;
    logic signed [DW-1:0] b_l;
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod;
    logic [DW-1:0]        add_sum;
    logic [DW-1:0]        add_res;
    logic [DW-1:0]        mul_res;
    logic [DW-1:0]        max_res;
    logic                 add_ovf;
    logic                 mul_ovf;

    assign a_l   = s1_a_q[gi*DW +: DW];
    assign b_l   = s1_b_q[gi*DW +: DW];
    // Sign-extend before multiplying so the PW-bit product is exact
    assign a_ext = a_l;
    assign b_ext = b_l;
    assign prod  = a_ext * b_ext;

    assign add_sum = a_l + b_l;
    assign add_ovf = (a_l[DW-1] == b_l[DW-1]) && (add_sum[DW-1] != a_l[DW-1]);
    // The product fits when its top DW+1 bits are all copies of the sign
    assign mul_ovf = ~((&prod[PW-1:DW-1]) | ~(|prod[PW-1:DW-1]));
    assign max_res = (a_l > b_l) ? a_l : b_l;

`ifdef VS_VEC_SATURATE_EN
    // On ADD overflow both operands share the true sign
    assign add_res = add_ovf ? (a_l[DW-1] ? SAT_MIN : SAT_MAX) : add_sum;
    assign mul_res = mul_ovf ? (prod[PW-1] ? SAT_MIN : SAT_MAX) : prod[DW-1:0];
`else
    assign add_res = add_sum;
    assign mul_res = prod[DW-1:0];
`endif

    assign lane_res_d[gi]  = (s1_op_q == OP_ADD) ? add_res :
                             (s1_op_q == OP_MUL) ? mul_res :
                             (s1_op_q == OP_MAX) ? max_res : '0;
    assign lane_ovf_d[gi]  = (s1_op_q == OP_ADD) ? add_ovf :
                             (s1_op_q == OP_MUL) ? mul_ovf : 1'b0;
    assign lane_prod_d[gi] = ((s1_op_q == OP_DP) && s1_mask_q[gi]) ? prod : '0;
  end

  // Register the per-lane results
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_op_q    <= '0;
      s2_res_q   <= '0;
      s2_ovf_q   <= '0;
      s2_prod_q  <= '0;
    end else if (!stall) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_op_q   <= s1_op_q;
        s2_res_q  <= lane_res_d;
        s2_ovf_q  <= lane_ovf_d;
        s2_prod_q <= lane_prod_d;
      end
    end
  end

  // Sum the masked products with enough headroom that the sum never wraps
  always_comb begin
    dp_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      dp_sum = dp_sum + {{(SW-PW){s2_prod_q[k][PW-1]}}, s2_prod_q[k]};
    end
  end

  assign dp_ovf = ~((&dp_sum[SW-1:DW-1]) | ~(|dp_sum[SW-1:DW-1]));

`ifdef VS_VEC_SATURATE_EN
  assign dp_lane0 = dp_ovf ? (dp_sum[SW-1] ? SAT_MIN : SAT_MAX) : dp_sum[DW-1:0];
`else
  assign dp_lane0 = dp_sum[DW-1:0];
`endif

  assign s3_res_d  = (s2_op_q == OP_DP) ? {{((LANES-1)*DW){1'b0}}, dp_lane0} : s2_res_q;
  assign s3_ovf_d  = (s2_op_q == OP_DP) ? dp_ovf : (|s2_ovf_q);
  assign s3_zero_d = ~(|s3_res_d);

  // Output registers; a bubble from stage 2 drops oValid but keeps the data
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_res_q  <= s3_res_d;
        out_zero_q <= s3_zero_d;
        out_ovf_q  <= s3_ovf_d;
      end
    end
  end

  assign oValid    = out_valid_q;
  assign oResult   = out_res_q;
  assign oZero     = out_zero_q;
  assign oOverflow = out_ovf_q;

endmodule

// File: tb/tb_vs_vec_core.sv
// tb_vs_vec_core: directed scoreboard bench for vs_vec_core (LANES=4, 32-bit).
// Define VS_VEC_SATURATE_EN for both bench and RTL to test the clamping build.
module tb_vs_vec_core;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [1:0] OP_DP  = 2'd2;
  localparam logic [1:0] OP_MAX = 2'd3;

  typedef struct {
    logic [127:0] res;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         iValid;
  logic         oReady;
  logic [127:0] iA;
  logic [127:0] iB;
  logic [1:0]   iALU_Op;
  logic [3:0]   iLaneMask;
  logic         oValid;
  logic         iReady;
  logic [127:0] oResult;
  logic         oZero;
  logic         oOverflow;

  int   total = 0;
  int   bad = 0;
  int   run = 0;
  int   max_run = 0;
  int   out_cnt = 0;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  vs_vec_core dut (
    .clk       (clk),
    .reset     (reset),
    .iValid    (iValid),
    .oReady    (oReady),
    .iA        (iA),
    .iB        (iB),
    .iALU_Op   (iALU_Op),
    .iLaneMask (iLaneMask),
    .oValid    (oValid),
    .iReady    (iReady),
    .oResult   (oResult),
    .oZero     (oZero),
    .oOverflow (oOverflow)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [127:0] r;
    r[31:0]   = l0;
    r[63:32]  = l1;
    r[95:64]  = l2;
    r[127:96] = l3;
    return r;
  endfunction

  // Reduce an exact value to a 32-bit lane, flagging values outside int32
  function automatic logic [31:0] fold(input longint v, output logic o);
    o = (v > 64'sd2147483647) || (v < -64'sd2147483648);
`ifdef VS_VEC_SATURATE_EN
    if (o) return (v < 0) ? 32'h80000000 : 32'h7FFFFFFF;
`endif
    return v[31:0];
  endfunction

  // Reference model using exact 64-bit arithmetic
  function automatic exp_t model(input logic [1:0] op, input logic [127:0] a,
                                 input logic [127:0] b, input logic [3:0] m);
    exp_t                e;
    longint              v;
    longint              acc;
    logic signed [31:0]  x;
    logic signed [31:0]  y;
    logic                o;
    e.res = '0;
    e.ovf = 1'b0;
    acc   = 0;
    for (int k = 0; k < 4; k++) begin
      x = a[k*32 +: 32];
      y = b[k*32 +: 32];
      if (op == OP_DP) begin
        if (m[k]) acc = acc + longint'(x) * longint'(y);
      end else begin
        case (op)
          OP_ADD:  v = longint'(x) + longint'(y);
          OP_MUL:  v = longint'(x) * longint'(y);
          default: v = (x > y) ? longint'(x) : longint'(y);
        endcase
        e.res[k*32 +: 32] = fold(v, o);
        e.ovf = e.ovf | o;
      end
    end
    if (op == OP_DP) begin
      e.res[31:0] = fold(acc, o);
      e.ovf = o;
    end
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Present one operation from the drive slot; push its expectation on accept
  task automatic send(input logic [1:0] op, input logic [127:0] a,
                      input logic [127:0] b, input logic [3:0] m);
    int guard;
    iValid = 1'b1; iALU_Op = op; iA = a; iB = b; iLaneMask = m;
    @(negedge clk);
    guard = 0;
    while (!oReady && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!oReady) chk("send_ready", oReady, 1);
    else q.push_back(model(op, a, b, m));
    @(posedge clk); #1;
    iValid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q.size() != 0 || oValid) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Output monitor: pops and checks each output transfer
  always @(negedge clk) begin
    if (reset) begin
      run = 0;
    end else begin
      if (oValid) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      if (oValid && iReady) begin
        out_cnt++;
        if (q.size() == 0) begin
          chk("spurious_out", oValid, 0);
        end else begin
          mon_e = q.pop_front();
          $display("out #%0d result=%h zero=%0b ovf=%0b", out_cnt, oResult, oZero, oOverflow);
          chk("result", oResult, mon_e.res);
          chk("zero", oZero, mon_e.zero);
          chk("ovf", oOverflow, mon_e.ovf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1; iValid = 1'b0; iReady = 1'b1;
    iA = '0; iB = '0; iALU_Op = '0; iLaneMask = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", oValid, 0);
    chk("rst_result", oResult, 0);
    chk("rst_zero", oZero, 0);
    chk("rst_ovf", oOverflow, 0);
    chk("rst_ready", oReady, 1);
    @(posedge clk); #1;

    // DP4 with latency check: oValid rises on the third edge from accept
    send(OP_DP, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b1111);
    @(negedge clk); chk("lat_c1", oValid, 0);
    @(negedge clk); chk("lat_c2", oValid, 0);
    @(negedge clk); chk("lat_c3", oValid, 1);
    @(posedge clk); #1;
    drain();

    // DP3, empty mask, ADD overflow boundaries, DP sum overflow
    send(OP_DP, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b0111);
    send(OP_DP, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b0000);
    send(OP_ADD, pack4(32'h7FFFFFFF, 0, 0, 0), pack4(1, 0, 0, 0), 4'b0000);
    send(OP_ADD, pack4(32'h80000000, 10, -3, 5), pack4(-1, -20, 3, 6), 4'b1111);
    send(OP_DP, pack4(32'h10000, 9, 9, 9), pack4(32'h10000, 9, 9, 9), 4'b0001);
    drain();

    // Back-to-back stream of 8 MUL ops
    for (int i = 0; i < 8; i++) begin
      send(OP_MUL, pack4(i + 1, -(i + 2), 1000 * i, 32'h10000),
                   pack4(3, i, -7, 32'h8000 * i), 4'b0000);
    end
    drain();
    chk("mul_stream_run", max_run, 8);

    // MAX
    send(OP_MAX, pack4(-5, -5, -5, -5), pack4(3, 3, 3, 3), 4'b0000);
    send(OP_MAX, pack4(-1, 32'h7FFFFFFF, 32'h80000000, 7), pack4(-2, -1, 5, 7), 4'b0000);
    drain();

    // Stall with three ops in flight and a fourth waiting at the input
    base = out_cnt;
    send(OP_ADD, pack4(11, 12, 13, 14), pack4(1, 1, 1, 1), 4'b0000);
    send(OP_MUL, pack4(2, 3, 4, 5), pack4(6, 7, 8, 9), 4'b0000);
    send(OP_DP, pack4(2, 3, 4, 5), pack4(6, 7, 8, 9), 4'b1011);
    iReady = 1'b0;
    iValid = 1'b1; iALU_Op = OP_MAX;
    iA = pack4(-9, 4, 0, 100); iB = pack4(-8, 5, 0, -100); iLaneMask = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_ready", oReady, 0);
      chk("stall_valid", oValid, 1);
      chk("stall_hold", oResult, q[0].res);
    end
    @(posedge clk); #1;
    iReady = 1'b1;
    @(negedge clk);
    chk("release_ready", oReady, 1);
    q.push_back(model(OP_MAX, iA, iB, iLaneMask));
    @(posedge clk); #1;
    iValid = 1'b0;
    drain();
    chk("stall_out_count", out_cnt - base, 4);

    // Reset with two ops in flight
    send(OP_ADD, pack4(7, 7, 7, 7), pack4(1, 2, 3, 4), 4'b0000);
    send(OP_MUL, pack4(7, 7, 7, 7), pack4(1, 2, 3, 4), 4'b0000);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    @(negedge clk);
    chk("mid_rst_ready", oReady, 1);
    chk("mid_rst_result", oResult, 0);
    chk("mid_rst_zero", oZero, 0);
    chk("mid_rst_ovf", oOverflow, 0);
    for (int c = 0; c < 5; c++) begin
      chk("mid_rst_valid", oValid, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // Pipe still works after the mid-flight reset
    send(OP_DP, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b1111);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vs_vec_core.md
Name: vs_vec_core

Overview:
- Parametrised successor to the fixed 4-lane shader core.
- N-lane, 3-stage pipelined vector ALU for the vertex shader datapath with element-wise ADD/MUL/MAX and a lane-masked dot product.
- Full valid/ready back-pressure on input and output.
- Sits between the vertex-shader operand fetch and the result write-back.

Parameters:
- LANES, 4, number of vector lanes (power of two, 2..8)
- DATA_WIDTH, 32, signed two's-complement lane width
- OP_WIDTH, 2, opcode width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- iValid  in  1  input operand valid
- oReady  out  1  core can accept input this cycle
- iA  in  LANES*DATA_WIDTH  vector A, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
- iB  in  LANES*DATA_WIDTH  vector B, same packing as iA
- iALU_Op  in  OP_WIDTH  0=ADD, 1=MUL, 2=DP, 3=MAX
- iLaneMask  in  LANES  lanes taking part in DP (DP3 = 4'b0111, DP4 = 4'b1111)
- oValid  out  1  result valid
- iReady  in  1  downstream accepts the result
- oResult  out  LANES*DATA_WIDTH  result vector
- oZero  out  1  every result lane is zero
- oOverflow  out  1  signed overflow in any active lane or in the DP sum

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled only on the rising edge of clk.
- Pipeline stages:
  - S1 registers the operands, op and mask.
  - S2 computes the per-lane op.
  - S3 reduces and registers the outputs.
- Latency is exactly 3 cycles, from the accepted input edge to the first cycle oValid=1. Throughput is 1 per cycle.
- Handshake:
  - An input transfer occurs when iValid & oReady at a rising edge.
  - An output transfer occurs when oValid & iReady.
  - oValid holds its value while iReady=0.
- Stall rules:
  - stall = oValid & ~iReady, and oReady = ~stall (combinational).
  - While stalled, every stage holds and S3 outputs are stable.
  - Bubbles do not propagate during a stall. No data is lost or duplicated.
- Per-lane operations in S2 (lane k):
  - ADD: A+B, wrapped to DATA_WIDTH. Overflow when the operand signs match and the result sign differs.
  - MUL: the low DATA_WIDTH bits of the 2*DATA_WIDTH signed product. Overflow when the upper DATA_WIDTH+1 bits are not all equal.
  - MAX: the signed maximum. Never overflows.
  - DP: the full 2*DATA_WIDTH signed product, forced to 0 when iLaneMask[k]=0.
- DP reduction in S3:
  - Sum the masked products at 2*DATA_WIDTH+$clog2(LANES) bits.
  - Result lane 0 = the low DATA_WIDTH bits; all other result lanes = 0.
  - Overflow when the full sum does not fit in signed DATA_WIDTH.
  - iLaneMask=0 gives result 0, oZero=1, oOverflow=0.
- iLaneMask is ignored for ADD/MUL/MAX; all lanes are active.
- oZero is evaluated on the final oResult (after saturation when VS_VEC_SATURATE_EN is defined).
- Reset values:
  - oValid=0, oResult=0, oZero=0, oOverflow=0.
  - All stage valids are 0, so oReady=1 in the cycle after reset.
- Reset mid-operation: all in-flight results are discarded, with no output transfer after the reset edge. Reset has priority over stall and input acceptance.
- Simultaneous output drain and input accept in the same cycle is legal and keeps full throughput.

Optional Feature:
- Macro: VS_VEC_SATURATE_EN.
- When defined:
  - ADD, MUL and DP results that overflow are clamped to 2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1) according to the true sign.
  - oOverflow still reports the event.
- When undefined: results wrap as described above, and no saturation logic is generated.

Test Plan:
- Reset, then DP with LANES=4, iLaneMask=4'b1111, A={1,2,3,4}, B={5,6,7,8}: 3 cycles later oValid=1, lane0=70, lanes1-3=0, oZero=0, oOverflow=0.
- Same operands with iLaneMask=4'b0111 (DP3): lane0=38. Mask 4'b0000: lane0=0, oZero=1.
- ADD with A lane0=0x7FFFFFFF, B lane0=1: wrap build gives 0x80000000 with oOverflow=1; VS_VEC_SATURATE_EN build gives 0x7FFFFFFF with oOverflow=1.
- Back-to-back stream of 8 MUL ops with iReady=1: 8 consecutive oValid cycles starting at cycle 3, results in order. MAX of {-5,3} lane-wise gives 3.
- Hold iReady=0 for 5 cycles with 3 ops in flight and iValid=1: oReady=0 during the stall, oResult stable; after release the results drain in order with none lost or duplicated.
- Assert reset for 1 cycle with 2 ops in flight: oValid=0 the next cycle and stays 0 with no spurious output, oReady=1, all outputs zero.
